// File: rtl/hrfp_normalize.sv
// HRFP_16 adder normalization stage: hex-digit overflow / leading-zero detection,
// whole-digit left shift and exponent-correction encoding, registered for rounding.
module hrfp_normalize #(
    parameter int EXPBITS    = 8,
    parameter int RESULTBITS = 37
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic [30:0]           sum_4,
    input  logic                  sticky_4,
    input  logic                  sign_4,
    input  logic [EXPBITS-1:0]    exp_4,
    output logic                  valid_5,
    output logic [30:0]           mantissa_5,
    output logic                  overflow_bit_5,
    output logic [30:0]           overflow_mantissa_5,
    output logic                  overflow_roundvector_5,
    output logic                  iszero_5,
    output logic [EXPBITS-1:0]    expdiff_5,
    output logic                  expdiff_addone_5,
    output logic                  expdiff_nochange_5,
    output logic [RESULTBITS-1:0] result_5,
    output logic                  expovf_5
);
    localparam int MANTBITS = RESULTBITS - 1 - EXPBITS;

    logic               valid_a;
    logic [30:0]        sum_a;
    logic               sticky_a;
    logic               sign_a;
    logic [EXPBITS-1:0] exp_a;
    logic [2:0]         lz_a;
    logic               allzero_a;
    logic               ovf_a;

    logic [2:0]         lz_next;
    logic               lz_found;

    // Count leading zero hex digits over [29:2]; the carry digit bit 30 is excluded.
    always_comb begin
        lz_next  = '0;
        lz_found = 1'b0;
        for (int unsigned d = 0; d < 7; d++) begin
            if (!lz_found && (sum_4[29 - 4*d -: 4] == 4'h0))
                lz_next = lz_next + 3'd1;
            else
                lz_found = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_a   <= 1'b0;
            sum_a     <= '0;
            sticky_a  <= 1'b0;
            sign_a    <= 1'b0;
            exp_a     <= '0;
            lz_a      <= '0;
            allzero_a <= 1'b0;
            ovf_a     <= 1'b0;
        end else if (!stall) begin
            valid_a   <= in_valid;
            sum_a     <= sum_4;
            sticky_a  <= sticky_4;
            sign_a    <= sign_4;
            exp_a     <= exp_4;
            lz_a      <= lz_next;
            allzero_a <= (sum_4 == '0) && !sticky_4;
            ovf_a     <= sum_4[30];
        end
    end

    logic [30:0]        shifted;
    logic               underflow;
    logic               zero_b;
    logic [EXPBITS-1:0] exp_field;

    // Overflow takes priority: underflow and zero detection only apply on the normal path.
    always_comb begin
        shifted   = sum_a << {lz_a, 2'b00};
        underflow = !ovf_a && (exp_a < EXPBITS'(lz_a));
        zero_b    = !ovf_a && (allzero_a || underflow);
        exp_field = underflow ? '0 : exp_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_5                <= 1'b0;
            mantissa_5             <= '0;
            overflow_bit_5         <= 1'b0;
            overflow_mantissa_5    <= '0;
            overflow_roundvector_5 <= 1'b0;
            iszero_5               <= 1'b0;
            expdiff_5              <= '0;
            expdiff_addone_5       <= 1'b0;
            expdiff_nochange_5     <= 1'b0;
            result_5               <= '0;
            expovf_5               <= 1'b0;
        end else if (!stall) begin
            valid_5                <= valid_a;
            overflow_bit_5         <= ovf_a;
            overflow_mantissa_5    <= ovf_a ? {4'h0, sum_a[30:4]} : '0;
            overflow_roundvector_5 <= ovf_a && (sum_a[7] || (|sum_a[5:0]) || sticky_a);
            iszero_5               <= zero_b;
            expdiff_5              <= ovf_a ? '0 : (EXPBITS'(lz_a) ^ EXPBITS'(4));
            expdiff_addone_5       <= ovf_a;
            expdiff_nochange_5     <= !ovf_a && !zero_b && (lz_a == 3'd0);
            expovf_5               <= ovf_a && (&exp_a);
            if (ovf_a)
                mantissa_5 <= sum_a;
            else if (zero_b)
                mantissa_5 <= '0;
            else
                mantissa_5 <= shifted | {30'b0, sticky_a};
            result_5               <= {sign_a, exp_field, {MANTBITS{1'b0}}};
        end
    end

endmodule

// File: tb/tb_hrfp_normalize.sv
// Bench for hrfp_normalize: directed and random transactions, expected bundles
// queued at issue and compared as each new output bundle appears.
module tb_hrfp_normalize;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic [30:0] sum_4 = '0;
    logic        sticky_4 = 1'b0;
    logic        sign_4 = 1'b0;
    logic [7:0]  exp_4 = '0;
    logic        valid_5;
    logic [30:0] mantissa_5;
    logic        overflow_bit_5;
    logic [30:0] overflow_mantissa_5;
    logic        overflow_roundvector_5;
    logic        iszero_5;
    logic [7:0]  expdiff_5;
    logic        expdiff_addone_5;
    logic        expdiff_nochange_5;
    logic [36:0] result_5;
    logic        expovf_5;

    hrfp_normalize #(.EXPBITS(8), .RESULTBITS(37)) dut (
        .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid),
        .sum_4(sum_4), .sticky_4(sticky_4), .sign_4(sign_4), .exp_4(exp_4),
        .valid_5(valid_5), .mantissa_5(mantissa_5), .overflow_bit_5(overflow_bit_5),
        .overflow_mantissa_5(overflow_mantissa_5),
        .overflow_roundvector_5(overflow_roundvector_5), .iszero_5(iszero_5),
        .expdiff_5(expdiff_5), .expdiff_addone_5(expdiff_addone_5),
        .expdiff_nochange_5(expdiff_nochange_5), .result_5(result_5), .expovf_5(expovf_5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [30:0] mant;
        logic        ovf_bit;
        logic [30:0] ovf_mant;
        logic        ovf_rv;
        logic        iszero;
        logic [7:0]  expdiff;
        logic        addone;
        logic        nochange;
        logic [36:0] result;
        logic        expovf;
    } exp_t;

    exp_t     q[$];
    exp_t     last;
    logic [1:0] vsh = '0;
    int       errors = 0;
    int       checks = 0;

    function automatic exp_t model(logic [30:0] s, logic st, logic sg, logic [7:0] e);
        exp_t        r;
        logic [30:0] m;
        int          lz;
        r = '0;
        if (s[30]) begin
            r.ovf_bit  = 1'b1;
            r.ovf_mant = s >> 4;
            r.ovf_rv   = s[7] | (|s[5:0]) | st;
            r.mant     = s;
            r.addone   = 1'b1;
            r.expovf   = (e == 8'hFF);
            r.result   = {sg, e, 28'h0};
        end else begin
            m  = s;
            lz = 0;
            while (lz < 7 && m[29:26] == 4'h0) begin
                m  = m << 4;
                lz = lz + 1;
            end
            r.expdiff  = 8'(lz) ^ 8'h04;
            r.iszero   = (s == '0 && !st) || (int'(e) < lz);
            r.nochange = !r.iszero && (lz == 0);
            r.mant     = r.iszero ? 31'h0 : (m | {30'b0, st});
            r.result   = {sg, (int'(e) < lz) ? 8'h00 : e, 28'h0};
        end
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_bundle(string tag, exp_t e);
        check({tag, ".mantissa"}, 64'(mantissa_5), 64'(e.mant));
        check({tag, ".ovf_bit"}, 64'(overflow_bit_5), 64'(e.ovf_bit));
        check({tag, ".ovf_mant"}, 64'(overflow_mantissa_5), 64'(e.ovf_mant));
        check({tag, ".ovf_rv"}, 64'(overflow_roundvector_5), 64'(e.ovf_rv));
        check({tag, ".iszero"}, 64'(iszero_5), 64'(e.iszero));
        check({tag, ".expdiff"}, 64'(expdiff_5), 64'(e.expdiff));
        check({tag, ".addone"}, 64'(expdiff_addone_5), 64'(e.addone));
        check({tag, ".nochange"}, 64'(expdiff_nochange_5), 64'(e.nochange));
        check({tag, ".result"}, 64'(result_5), 64'(e.result));
        check({tag, ".expovf"}, 64'(expovf_5), 64'(e.expovf));
    endtask

    // One clock: enqueue what this edge accepts, then check what the edge produced.
    task automatic cycle();
        logic st_at, v_at, r_at;
        st_at = stall;
        v_at  = in_valid;
        r_at  = rst;
        if (!r_at && !st_at && v_at)
            q.push_back(model(sum_4, sticky_4, sign_4, exp_4));
        @(posedge clk);
        #1;
        if (r_at)
            vsh = '0;
        else if (!st_at)
            vsh = {vsh[0], v_at};
        check("valid_5", 64'(valid_5), 64'(vsh[1]));
        if (valid_5 && !r_at) begin
            if (!st_at) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL q_underrun observed=%0d expected=>0", q.size());
                end
                if (q.size() > 0) begin
                    last = q.pop_front();
                    check_bundle("out", last);
                end
            end else begin
                check_bundle("held", last);
            end
        end
    endtask

    task automatic drive(logic v, logic [30:0] s, logic st, logic sg, logic [7:0] e);
        in_valid = v;
        sum_4    = s;
        sticky_4 = st;
        sign_4   = sg;
        exp_4    = e;
        cycle();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 31'h0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [30:0] s;
        logic [7:0]  e;

        // reset state
        rst = 1'b1;
        cycle();
        cycle();
        check_bundle("reset", '0);
        rst = 1'b0;

        // directed cases
        drive(1'b1, 31'h40000000, 1'b0, 1'b0, 8'h40);
        drive(1'b1, 31'h20000000, 1'b0, 1'b1, 8'h40);
        drive(1'b1, 31'h00008000, 1'b0, 1'b0, 8'h40);
        drive(1'b1, 31'h00000000, 1'b0, 1'b0, 8'h40);
        drive(1'b1, 31'h00000004, 1'b0, 1'b1, 8'h03);
        drive(1'b1, 31'h40000000, 1'b0, 1'b0, 8'hFF);
        drive(1'b1, 31'h40000080, 1'b0, 1'b0, 8'h10);
        drive(1'b1, 31'h40000040, 1'b0, 1'b1, 8'h10);
        drive(1'b1, 31'h40000000, 1'b1, 1'b0, 8'h10);
        drive(1'b1, 31'h00000000, 1'b1, 1'b0, 8'h20);
        drive(1'b1, 31'h00000010, 1'b1, 1'b0, 8'h05);
        drive(1'b1, 31'h00000010, 1'b0, 1'b0, 8'h04);
        idle(3);

        // back-to-back with a three-cycle stall mid-stream
        drive(1'b1, 31'h01234567, 1'b0, 1'b0, 8'h22);
        drive(1'b1, 31'h00ABCDEF, 1'b1, 1'b1, 8'h33);
        drive(1'b1, 31'h4FFFFFFF, 1'b0, 1'b0, 8'h44);
        stall = 1'b1;
        drive(1'b1, 31'h11111111, 1'b0, 1'b0, 8'h55);
        drive(1'b1, 31'h22222222, 1'b0, 1'b0, 8'h66);
        drive(1'b1, 31'h33333333, 1'b0, 1'b0, 8'h77);
        stall = 1'b0;
        drive(1'b1, 31'h00000F00, 1'b0, 1'b1, 8'h88);
        drive(1'b1, 31'h3C000000, 1'b0, 1'b0, 8'h99);
        idle(3);

        // reset mid-stream: outputs clear at once, next input emerges two edges later
        drive(1'b1, 31'h12345678, 1'b0, 1'b0, 8'h12);
        drive(1'b1, 31'h00345678, 1'b0, 1'b0, 8'h13);
        drive(1'b1, 31'h00005678, 1'b0, 1'b0, 8'h14);
        rst = 1'b1;
        #1;
        check("rst_async.valid_5", 64'(valid_5), 64'(0));
        check("rst_async.mantissa_5", 64'(mantissa_5), 64'(0));
        q.delete();
        vsh = '0;
        in_valid = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b1, 31'h00F00000, 1'b0, 1'b1, 8'h21);
        idle(3);

        // random traffic with occasional stalls
        for (int i = 0; i < 60; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            s = 31'($urandom) >> $urandom_range(0, 30);
            s[30] = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 8)) : 8'($urandom);
            drive(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), e);
        end
        stall = 1'b0;
        idle(4);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL q_drained observed=%0d expected=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hrfp_normalize.md
Name: hrfp_normalize

Overview:
- Normalization stage of the HRFP_16 adder, directly upstream of the rounding stage.
- Takes the raw post-add/subtract mantissa, sign and exponent from the alignment/add stage.
- Detects hex-digit carry-out (overflow) or leading zero hex digits, shifts left in whole hex digits, and builds the exponent-correction encoding and sticky-based round information.
- Registers everything into the stage-5 bundle consumed by rounding.

Parameters:
- EXPBITS, 8, exponent field width.
- RESULTBITS, 37, width of the packed result word: sign at MSB, then EXPBITS of exponent, then mantissa bits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freezes both pipeline registers.
- in_valid  in  1  input bundle valid.
- sum_4  in  31  raw mantissa: bit 30 = hex carry-out, [29:26] leading hex digit, [1:0] guard bits.
- sticky_4  in  1  OR of bits lost during alignment.
- sign_4  in  1  result sign.
- exp_4  in  EXPBITS  pre-normalization exponent.
- valid_5  out  1  output bundle valid.
- mantissa_5  out  31  left-normalized mantissa.
- overflow_bit_5  out  1  carry-out case.
- overflow_mantissa_5  out  31  sum shifted right one hex digit.
- overflow_roundvector_5  out  1  round/sticky bit for the overflow path.
- iszero_5  out  1  result is zero.
- expdiff_5  out  EXPBITS  encoded leading-zero count.
- expdiff_addone_5  out  1  exponent +1.
- expdiff_nochange_5  out  1  exponent unchanged.
- result_5  out  RESULTBITS  sign and exponent; mantissa field zero.
- expovf_5  out  1  exponent overflow on carry-out.

Behaviour:
- Reset (async, active-high): every register and every output is 0, including valid_5. Reset mid-operation discards in-flight data immediately.
- Pipeline:
  - Latency 2 cycles; throughput 1 per cycle.
  - Stage A registers the inputs, the leading-zero digit count lz[2:0], the allzero flag and the overflow flag.
  - Stage B registers the shifted mantissa and all outputs.
  - stall=1 holds both stages and valid_5 unchanged; inputs presented during stall are ignored.
  - Valid propagates through both stages alongside data. When valid=0, data registers still load, but the consumer ignores them.
- Overflow (sum_4[30]=1):
  - overflow_bit_5=1.
  - overflow_mantissa_5 = sum_4 >> 4.
  - overflow_roundvector_5 = sum_4[7] | (|sum_4[5:0]) | sticky_4.
  - expdiff_addone_5=1, expdiff_nochange_5=0, mantissa_5 = sum_4 unshifted.
  - expovf_5 = 1 when exp_4 is all ones; otherwise 0.
- Normal path (sum_4[30]=0):
  - lz = number of leading all-zero digits among [29:26],[25:22],…,[5:2]; range 0..7.
  - mantissa_5 = sum_4 << (4*lz), zero-filled, with sticky_4 ORed into bit 0.
  - expdiff_5 = zero-extended lz XOR 8'h04.
  - expdiff_nochange_5 = (lz==0); expdiff_addone_5 = 0.
  - overflow_mantissa_5 and overflow_roundvector_5 are 0.
- Zero:
  - iszero_5 = 1 when sum_4[30:0]==0 and sticky_4==0.
  - iszero_5 = 1 also on underflow (exp_4 < lz). In that case the result_5 exponent field and mantissa_5 are 0.
  - When iszero_5=1, expdiff_addone_5=0 and expdiff_nochange_5=0.
- result_5 = {sign_4, exp_4, zeros}. Exponent correction is applied downstream only.
- Overflow has priority over the zero and lz logic.

Test Plan:
- sum_4=31'h40000000, exp_4=8'h40, sticky_4=0 -> after 2 cycles: overflow_bit_5=1, overflow_mantissa_5=31'h04000000, expdiff_addone_5=1, overflow_roundvector_5=0.
- sum_4=31'h20000000, exp_4=8'h40 -> lz=0, mantissa_5=31'h20000000, expdiff_nochange_5=1, expdiff_5=8'h04.
- sum_4=31'h00008000, exp_4=8'h40 -> lz=3, mantissa_5=31'h08000000, expdiff_5=8'h07, expdiff_nochange_5=0.
- sum_4=0, sticky_4=0 -> iszero_5=1. Separately: sum_4=31'h00000004, exp_4=8'h03 (lz=6>3) -> iszero_5=1, result_5 exponent=0.
- Overflow with exp_4=8'hFF -> expovf_5=1. Overflow with sum_4=31'h40000080 -> overflow_roundvector_5=1.
- Back-to-back valids with stall held 3 cycles mid-stream -> outputs frozen, no loss or duplication. Assert rst mid-stream -> valid_5=0 in the same cycle; the next input appears 2 cycles after rst deasserts.
